// File: rtl/memwb_writeback.sv
// MEM/WB pipeline register and write-back result mux. It holds the pipe while a load waits on
// data memory, commits HALT and flags memory errors and load timeouts.
module memwb_writeback #(
  parameter int DATA_W      = 16,
  parameter int MEM_TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_instruct,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_pcinc,
  input  logic              ex_regwrite,
  input  logic [1:0]        ex_regdst,
  input  logic              ex_memtoreg,
  input  logic              ex_pctoreg,
  input  logic              ex_halt,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_err,
  output logic [DATA_W-1:0] wb,
  output logic              RegWrite_todec,
  output logic [1:0]        RegDst_todec,
  output logic [DATA_W-1:0] WriteInstruct,
  output logic [DATA_W-1:0] data_memwb,
  output logic              wb_stall,
  output logic              halt_out,
  output logic              err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, COMMIT, WAITLD, HALTED} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              halted;
  logic              timed_out;
  logic              accept;
  logic [DATA_W-1:0] result;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    halted    = (state == HALTED);
    timed_out = (state == WAITLD) && (wait_cnt == CNT_W'(MEM_TIMEOUT));
    wb_stall  = ex_valid & ex_memtoreg & ~mem_done & ~halted & ~timed_out;
    accept    = ex_valid & ~(ex_memtoreg & ~mem_done) & ~halted;
    result    = ex_alu;
    if (ex_memtoreg)     result = mem_data;
    else if (ex_pctoreg) result = ex_pcinc;
  end

  assign data_memwb = wb;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      wb             <= '0;
      RegWrite_todec <= 1'b0;
      RegDst_todec   <= '0;
      WriteInstruct  <= '0;
      halt_out       <= 1'b0;
      err            <= 1'b0;
    end else if (halted) begin
      RegWrite_todec <= 1'b0;
    end else if (accept) begin
      wb             <= result;
      RegDst_todec   <= ex_regdst;
      WriteInstruct  <= ex_instruct;
      RegWrite_todec <= ex_regwrite & ~ex_halt;
      wait_cnt       <= '0;
      state          <= ex_halt ? HALTED : COMMIT;
      if (ex_halt)               halt_out <= 1'b1;
      if (ex_memtoreg & mem_err) err      <= 1'b1;
    end else begin
      // Bubble: write-back data holds, only the write enable drops.
      RegWrite_todec <= 1'b0;
      if (wb_stall) begin
        state    <= WAITLD;
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        state    <= IDLE;
        wait_cnt <= '0;
      end
      if (timed_out) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memwb_writeback.sv
// Scoreboard bench for memwb_writeback: expected RF writes are queued when driven and
// compared whenever the DUT asserts RegWrite_todec; control outputs are checked directly.
module tb_memwb_writeback;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, ex_regwrite, ex_memtoreg, ex_pctoreg, ex_halt;
  logic [DW-1:0] ex_instruct, ex_alu, ex_pcinc, mem_data;
  logic [1:0]    ex_regdst;
  logic          mem_done, mem_err;
  logic [DW-1:0] wb, WriteInstruct, data_memwb;
  logic          RegWrite_todec, wb_stall, halt_out, err;
  logic [1:0]    RegDst_todec;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    dst;
    logic [DW-1:0] instr;
  } wr_t;

  wr_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;

  memwb_writeback #(.DATA_W(DW), .MEM_TIMEOUT(31)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_instruct(ex_instruct), .ex_alu(ex_alu), .ex_pcinc(ex_pcinc),
    .ex_regwrite(ex_regwrite), .ex_regdst(ex_regdst), .ex_memtoreg(ex_memtoreg),
    .ex_pctoreg(ex_pctoreg), .ex_halt(ex_halt),
    .mem_done(mem_done), .mem_data(mem_data), .mem_err(mem_err),
    .wb(wb), .RegWrite_todec(RegWrite_todec), .RegDst_todec(RegDst_todec),
    .WriteInstruct(WriteInstruct), .data_memwb(data_memwb), .wb_stall(wb_stall),
    .halt_out(halt_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every RF write the DUT issues must match the oldest queued expectation.
  always @(negedge clk) begin
    if (RegWrite_todec === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_write", 32'(RegWrite_todec), 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wb", 32'(wb), 32'(e.data));
        check("data_memwb", 32'(data_memwb), 32'(e.data));
        check("regdst", 32'(RegDst_todec), 32'(e.dst));
        check("instr", 32'(WriteInstruct), 32'(e.instr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid = 0; ex_regwrite = 0; ex_memtoreg = 0; ex_pctoreg = 0; ex_halt = 0;
    ex_instruct = '0; ex_alu = '0; ex_pcinc = '0; ex_regdst = '0;
    mem_done = 0; mem_data = '0; mem_err = 0;
  endtask

  task automatic set_op(input logic [DW-1:0] instr, input logic [DW-1:0] alu,
                        input logic [DW-1:0] pcinc, input logic [1:0] dst,
                        input logic rw, input logic m2r, input logic p2r);
    idle_in();
    ex_valid = 1; ex_instruct = instr; ex_alu = alu; ex_pcinc = pcinc;
    ex_regdst = dst; ex_regwrite = rw; ex_memtoreg = m2r; ex_pctoreg = p2r;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wb"}, 32'(wb), 32'd0);
    check({tag, "_regwrite"}, 32'(RegWrite_todec), 32'd0);
    check({tag, "_regdst"}, 32'(RegDst_todec), 32'd0);
    check({tag, "_instr"}, 32'(WriteInstruct), 32'd0);
    check({tag, "_halt"}, 32'(halt_out), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DW-1:0] r;
    idle_in();
    rst = 1;
    tick();
    tick();
    @(negedge clk);
    check_zero("reset");
    rst = 0;

    // ADDI: one write one cycle later, data holds after
    tick();
    set_op(16'h5047, 16'h0007, 16'h0010, 2'd1, 1, 0, 0);
    sb.push_back('{16'h0007, 2'd1, 16'h5047});
    @(negedge clk);
    check("addi_stall", 32'(wb_stall), 32'd0);
    tick();
    idle_in();
    @(negedge clk);
    check("addi_we", 32'(RegWrite_todec), 32'd1);
    tick();
    @(negedge clk);
    check("addi_we_drop", 32'(RegWrite_todec), 32'd0);
    check("addi_hold", 32'(wb), 32'h0007);

    // Load miss for 3 cycles then hit
    set_op(16'h8123, 16'h0100, 16'h0012, 2'd2, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ld_stall", 32'(wb_stall), 32'd1);
      check("ld_no_we", 32'(RegWrite_todec), 32'd0);
      tick();
    end
    mem_done = 1; mem_data = 16'hBEEF;
    sb.push_back('{16'hBEEF, 2'd2, 16'h8123});
    @(negedge clk);
    check("ld_hit_stall", 32'(wb_stall), 32'd0);
    tick();
    idle_in();
    @(negedge clk);
    check("ld_we", 32'(RegWrite_todec), 32'd1);
    check("ld_wb", 32'(wb), 32'hBEEF);

    // JAL selects pcinc over alu
    tick();
    set_op(16'h3001, 16'h1234, 16'h0042, 2'd3, 1, 0, 1);
    sb.push_back('{16'h0042, 2'd3, 16'h3001});
    tick();
    idle_in();
    @(negedge clk);
    check("jal_wb", 32'(wb), 32'h0042);
    check("jal_dst", 32'(RegDst_todec), 32'd3);

    // memtoreg wins over pctoreg; zero-cycle load needs no stall
    tick();
    set_op(16'h8456, 16'h1111, 16'h2222, 2'd0, 1, 1, 1);
    mem_done = 1; mem_data = 16'hCAFE;
    sb.push_back('{16'hCAFE, 2'd0, 16'h8456});
    @(negedge clk);
    check("ld0_stall", 32'(wb_stall), 32'd0);

    // Back-to-back ALU ops, some without a write
    for (int i = 0; i < 8; i++) begin
      tick();
      r = DW'($urandom);
      set_op(DW'(16'h4000 + i), r, 16'h0000, 2'(i), (i % 3) != 2, 0, 0);
      if ((i % 3) != 2) sb.push_back('{r, 2'(i), DW'(16'h4000 + i)});
    end
    tick();
    idle_in();
    @(negedge clk);
    check("bubble_hold_instr", 32'(WriteInstruct), 32'h4007);

    // Timeout: 31 stalled cycles, then err and no write
    tick();
    set_op(16'h8999, 16'h0000, 16'h0000, 2'd1, 1, 1, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!wb_stall) break;
      n++;
      tick();
    end
    check("to_stall_cycles", 32'(n), 32'd31);
    check("to_err_before", 32'(err), 32'd0);
    tick();
    idle_in();
    @(negedge clk);
    check("to_err", 32'(err), 32'd1);
    check("to_no_we", 32'(RegWrite_todec), 32'd0);
    tick();
    @(negedge clk);
    check("to_err_sticky", 32'(err), 32'd1);
    do_reset();
    @(negedge clk);
    check("to_err_clear", 32'(err), 32'd0);

    // mem_err on accepted load: err set and the data still written
    tick();
    set_op(16'h8777, 16'h0000, 16'h0000, 2'd2, 1, 1, 0);
    mem_done = 1; mem_data = 16'h1357; mem_err = 1;
    sb.push_back('{16'h1357, 2'd2, 16'h8777});
    tick();
    idle_in();
    @(negedge clk);
    check("merr_err", 32'(err), 32'd1);
    check("merr_we", 32'(RegWrite_todec), 32'd1);
    do_reset();

    // Halt: sticky, later instructions ignored, no stall in HALTED
    tick();
    set_op(16'h0000, 16'h0055, 16'h0000, 2'd1, 1, 0, 0);
    ex_halt = 1;
    tick();
    set_op(16'hD00A, 16'h00AA, 16'h0000, 2'd2, 1, 0, 0);
    @(negedge clk);
    check("halt_out", 32'(halt_out), 32'd1);
    check("halt_no_we", 32'(RegWrite_todec), 32'd0);
    tick();
    set_op(16'h8001, 16'h0000, 16'h0000, 2'd1, 1, 1, 0);
    @(negedge clk);
    check("halt_no_stall", 32'(wb_stall), 32'd0);
    tick();
    tick();
    @(negedge clk);
    check("halt_sticky", 32'(halt_out), 32'd1);
    check("halt_we_low", 32'(RegWrite_todec), 32'd0);
    do_reset();
    @(negedge clk);
    check_zero("halt_rst");

    // Reset mid-WAITLD with mem_done in the same cycle
    tick();
    set_op(16'h8ABC, 16'h0000, 16'h0000, 2'd3, 1, 1, 0);
    tick();
    tick();
    rst = 1; mem_done = 1; mem_data = 16'hDEAD;
    tick();
    rst = 0;
    idle_in();
    @(negedge clk);
    check_zero("rst_wait");

    // Pipe works again after reset
    tick();
    set_op(16'h5123, 16'h0099, 16'h0000, 2'd1, 1, 0, 0);
    sb.push_back('{16'h0099, 2'd1, 16'h5123});
    tick();
    idle_in();
    @(negedge clk);
    check("post_rst_we", 32'(RegWrite_todec), 32'd1);
    tick();
    tick();
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
